bcd_seq_converter: RTL and testbench

Sequential binary-to-BCD converter that sequences the switch-value-to-seven-segment display path. It accepts a WIDTH-bit switch value plus a signed/unsigned mode flag through a valid/ready handshake. It takes the magnitude, runs an iterative shift-add-3 (double-dabble) loop of one bit per clock, and returns a sign flag plus DIGITS BCD digits to the display encoder. It replaces the combinational divide/modulo chain, which synthesizes to large dividers.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_add3.sv | 21 ++
 rtl/bcd_seq_converter.sv | 158 +++++++++++++++
 tb/tb_bcd_seq_converter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared state type, digit constants and sizing helper for the sequential
// binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_e;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // Bits needed to hold a count from 0 up to and including width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble digit correction: adds 3 when the digit is 5 or more so
// that the following left shift carries correctly into the next decade.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  localparam logic [BCD_DIGIT_W-1:0] ADD3_OFFSET = 4'd3;

  // Conditional +3 correction of a single BCD digit.
  always_comb begin
    if (digit_i >= ADD3_THRESH) begin
      digit_o = digit_i + ADD3_OFFSET;
    end else begin
      digit_o = digit_i;
    end
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// Iterative binary-to-BCD converter, one magnitude bit per clock, with sign
// handling. Optional leading-zero blank mask: BCD_SEQ_LEADING_ZERO_BLANK_EN.
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int DIGITS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_value,
  input  logic                          in_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_neg,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic [DIGITS-1:0]             out_blank,
  output logic                          busy
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  bcd_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BCD_W-1:0] bcd_q;
  logic [WIDTH-1:0] mag_q;
  logic             neg_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             out_neg_q;
  logic [BCD_W-1:0] out_bcd_q;

  logic             neg_in_d;
  logic [WIDTH-1:0] mag_in_d;
  logic [BCD_W-1:0] bcd_add_s;
  logic [BCD_W-1:0] bcd_d;
  logic [WIDTH-1:0] mag_d;
  logic             unused_msb_s;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i(bcd_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(bcd_add_s[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Sign and magnitude of the request; the most negative value wraps to a
  // magnitude that still fits WIDTH bits unsigned.
  always_comb begin
    neg_in_d = in_signed & in_value[WIDTH-1];
    if (neg_in_d) begin
      mag_in_d = ~in_value + VAL_ONE;
    end else begin
      mag_in_d = in_value;
    end
  end

  // The top corrected bit is always shifted out as zero because the digit
  // range exceeds the input range.
  assign bcd_d        = {bcd_add_s[BCD_W-2:0], mag_q[WIDTH-1]};
  assign mag_d        = {mag_q[WIDTH-2:0], 1'b0};
  assign unused_msb_s = bcd_add_s[BCD_W-1];

`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_d;
  logic [DIGITS-1:0] out_blank_q;
  logic              zero_above_s;

  // Blank a digit when it and every digit above it are zero; units never blank.
  always_comb begin
    blank_d      = '0;
    zero_above_s = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_above_s = zero_above_s & (bcd_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_d[i]   = zero_above_s;
    end
  end

  assign out_blank = out_blank_q;
`else
  assign out_blank = '0;
`endif

  // Control FSM, datapath shift register and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bcd_q       <= '0;
      mag_q       <= '0;
      neg_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_neg_q   <= 1'b0;
      out_bcd_q   <= '0;
`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
      out_blank_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            neg_q      <= neg_in_d;
            mag_q      <= mag_in_d;
            bcd_q      <= '0;
            cnt_q      <= CNT_LOAD;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= bcd_d;
          mag_q <= mag_d;
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            out_bcd_q   <= bcd_d;
            out_neg_q   <= neg_q;
`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
            out_blank_q <= blank_d;
`endif
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_neg   = out_neg_q;
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: an arithmetic reference model checked
// against the DUT every cycle, plus hand-computed literal results.
module tb_bcd_seq_converter;

  localparam int WIDTH  = 10;
  localparam int DIGITS = 4;
  localparam int BCD_W  = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_value;
  logic              in_signed;
  logic              out_valid;
  logic              out_ready;
  logic              out_neg;
  logic [BCD_W-1:0]  out_bcd;
  logic [DIGITS-1:0] out_blank;
  logic              busy;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_value(in_value), .in_signed(in_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out_neg(out_neg), .out_bcd(out_bcd),
    .out_blank(out_blank), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the integer value.
  function automatic int model_mag(input logic [WIDTH-1:0] v, input logic s);
    if (s && v[WIDTH-1]) return (1 << WIDTH) - int'(v);
    return int'(v);
  endfunction

  function automatic logic model_neg(input logic [WIDTH-1:0] v, input logic s);
    return s && (model_mag(v, s) != int'(v) || v[WIDTH-1]) && model_mag(v, s) != 0;
  endfunction

  function automatic logic [BCD_W-1:0] model_bcd(input logic [WIDTH-1:0] v, input logic s);
    int m;
    logic [BCD_W-1:0] r;
    m = model_mag(v, s);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] model_blank(input logic [WIDTH-1:0] v, input logic s);
    logic [BCD_W-1:0] b;
    logic [DIGITS-1:0] r;
    int top;
    b = model_bcd(v, s);
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (b[4*i +: 4] != 4'd0) top = i;
    r = '0;
`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
    for (int i = 1; i < DIGITS; i++) r[i] = (i > top);
`endif
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] blank_lit(input logic [DIGITS-1:0] b);
`ifdef BCD_SEQ_LEADING_ZERO_BLANK_EN
    return b;
`else
    return '0;
`endif
  endfunction

  // Per-cycle compare against the model's view of timing and results.
  logic              pend = 1'b0;
  int                pend_cyc, age;
  logic [BCD_W-1:0]  pend_bcd, last_bcd;
  logic              pend_neg, last_neg;
  logic [DIGITS-1:0] pend_blank, last_blank;
  logic              v_exp, b_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0;
      last_bcd = '0; last_neg = 1'b0; last_blank = '0;
    end else begin
      age   = cyc - pend_cyc;
      v_exp = pend && (age >= WIDTH + 1);
      b_exp = pend && (age >= 1) && (age <= WIDTH);
      chk("in_ready", in_ready, !pend);
      chk("busy", busy, b_exp);
      chk("out_valid", out_valid, v_exp);
      chk("out_bcd", out_bcd, v_exp ? pend_bcd : last_bcd);
      chk("out_neg", out_neg, v_exp ? pend_neg : last_neg);
      chk("out_blank", out_blank, v_exp ? pend_blank : last_blank);
      if (v_exp && out_ready) begin
        last_bcd = pend_bcd; last_neg = pend_neg; last_blank = pend_blank;
        pend = 1'b0;
      end else if (!pend && in_valid) begin
        pend       = 1'b1;
        pend_cyc   = cyc;
        pend_bcd   = model_bcd(in_value, in_signed);
        pend_neg   = model_neg(in_value, in_signed);
        pend_blank = model_blank(in_value, in_signed);
      end
    end
  end

  task automatic start(input logic [WIDTH-1:0] v, input logic s);
    logic ok;
    @(posedge clk); #1;
    in_value = v; in_signed = s; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic consume();
    @(posedge clk); #1; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic conv(input logic [WIDTH-1:0] v, input logic s, input logic [BCD_W-1:0] eb,
                      input logic en, input logic [DIGITS-1:0] ebl);
    chk("model_bcd", model_bcd(v, s), eb);
    chk("model_neg", model_neg(v, s), en);
    chk("model_blank", model_blank(v, s), blank_lit(ebl));
    start(v, s);
    wait_valid();
    chk("lit_bcd", out_bcd, eb);
    chk("lit_neg", out_neg, en);
    chk("lit_blank", out_blank, blank_lit(ebl));
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_signed = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    conv(10'h3FF, 1'b0, 16'h1023, 1'b0, 4'b0000);
    conv(10'h200, 1'b1, 16'h0512, 1'b1, 4'b1000);
    conv(10'h200, 1'b0, 16'h0512, 1'b0, 4'b1000);
    conv(10'h3FF, 1'b1, 16'h0001, 1'b1, 4'b1110);
    conv(10'h000, 1'b1, 16'h0000, 1'b0, 4'b1110);
    conv(10'h1FF, 1'b1, 16'h0511, 1'b0, 4'b1000);
    conv(10'h301, 1'b1, 16'h0255, 1'b1, 4'b1000);

    // Backpressure with a request waiting behind the held result.
    start(10'h07B, 1'b0);
    wait_valid();
    chk("bp_first", out_bcd, 16'h0123);
    @(posedge clk); #1;
    in_value = 10'h3E7; in_signed = 1'b0; in_valid = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("bp_hold_bcd", out_bcd, 16'h0123);
    chk("bp_hold_valid", out_valid, 1'b1);
    chk("bp_hold_ready", in_ready, 1'b0);
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_reaccept_ready", in_ready, 1'b1);
    @(posedge clk); #1 in_valid = 1'b0;
    wait_valid();
    chk("bp_second", out_bcd, 16'h0999);
    consume();

    // Reset in the middle of a conversion.
    start(10'h155, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_bcd", out_bcd, 16'h0000);
    conv(10'h155, 1'b0, 16'h0341, 1'b0, 4'b1000);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
